// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS board I/O peripheral: register offsets, reset values,
// and the seven-segment glyph table with its decode function.
package mips_io_pkg;

    localparam logic [4:0] OFS_HEX   = 5'h00;
    localparam logic [4:0] OFS_LEDR  = 5'h04;
    localparam logic [4:0] OFS_LEDG  = 5'h08;
    localparam logic [4:0] OFS_SW    = 5'h0C;
    localparam logic [4:0] OFS_KEY   = 5'h10;
    localparam logic [4:0] OFS_EDGE  = 5'h14;
    localparam logic [4:0] OFS_BLANK = 5'h18;

    localparam int NUM_KEYS = 4;
    localparam int NUM_HEX  = 8;
    localparam int SW_W     = 18;
    localparam int LEDR_W   = 18;
    localparam int LEDG_W   = 9;

    localparam logic [31:0]         HEX_RST        = 32'h0;
    localparam logic [LEDR_W-1:0]   LEDR_RST       = '0;
    localparam logic [LEDG_W-1:0]   LEDG_RST       = '0;
    localparam logic [NUM_KEYS-1:0] EDGE_RST       = '0;
    localparam logic [NUM_HEX-1:0]  BLANK_RST      = '0;
    localparam logic                KEY_N_SYNC_RST = 1'b1;
    localparam logic [SW_W-1:0]     SW_SYNC_RST    = '0;

    // Segments are {g,f,e,d,c,b,a}, active-low; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [6:0] SEG_DARK = 7'h7F;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/mips_io_ctrl_key_debounce.sv
// One board key: two-flop synchroniser, stability counter and debounced state,
// with a single-cycle pulse when the debounced state goes released -> pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic state_o,
    output logic rise_o
);
    import mips_io_pkg::*;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       mode;
    logic             expire;

    // The state is implied by comparing the synced level against the accepted one.
    assign mode   = ((~sync2_q) != state_q) ? ST_COUNTING : ST_STABLE;
    assign expire = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_o  = 1'b0;
        if (mode == ST_COUNTING) begin
            if (expire) begin
                state_d = ~state_q;
                rise_o  = ~state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= KEY_N_SYNC_RST;
            sync2_q <= KEY_N_SYNC_RST;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mips_io_ctrl.sv
// Memory-mapped DE2 board I/O on the MIPS data bus: HEX/LED outputs, SW and debounced KEY inputs.
// Define MIPS_IO_HEX_BLANK_EN to add the per-digit HEX_BLANK register at offset 0x18.
module mips_io_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        io_hit,
    input  logic [3:0]  key_n,
    input  logic [17:0] sw,
    output logic [6:0]  hex7,
    output logic [6:0]  hex6,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic [17:0] ledr,
    output logic [8:0]  ledg
);
    import mips_io_pkg::*;

    logic [2:0]                reg_idx;
    logic                      wr;
    logic [31:0]               hex_q, hex_d;
    logic [LEDR_W-1:0]         ledr_q, ledr_d;
    logic [LEDG_W-1:0]         ledg_q, ledg_d;
    logic [NUM_KEYS-1:0]       edge_q, edge_d, edge_clr;
    logic [NUM_KEYS-1:0]       key_state, key_rise;
    logic [SW_W-1:0]           sw_sync1_q, sw_sync2_q;
    logic [NUM_HEX-1:0]        blank_q;
    logic [NUM_HEX-1:0][6:0]   hex_seg;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];
    assign io_hit  = (addr[31:5] == BASE_ADDR[31:5]);
    assign reg_idx = addr[4:2];
    assign wr      = io_hit & we;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .key_n_i(key_n[k]),
            .state_o(key_state[k]),
            .rise_o (key_rise[k])
        );
    end

    always_comb begin
        hex_d    = hex_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        edge_clr = '0;
        if (wr) begin
            case (reg_idx)
                OFS_HEX[4:2]:  hex_d    = wdata;
                OFS_LEDR[4:2]: ledr_d   = wdata[LEDR_W-1:0];
                OFS_LEDG[4:2]: ledg_d   = wdata[LEDG_W-1:0];
                OFS_EDGE[4:2]: edge_clr = wdata[NUM_KEYS-1:0];
                default: ;
            endcase
        end
        // A press landing in the same cycle as its clear must not be lost.
        edge_d = (edge_q & ~edge_clr) | key_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q      <= HEX_RST;
            ledr_q     <= LEDR_RST;
            ledg_q     <= LEDG_RST;
            edge_q     <= EDGE_RST;
            sw_sync1_q <= SW_SYNC_RST;
            sw_sync2_q <= SW_SYNC_RST;
        end else begin
            hex_q      <= hex_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            edge_q     <= edge_d;
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
        end
    end

`ifdef MIPS_IO_HEX_BLANK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= BLANK_RST;
        end else if (wr && reg_idx == OFS_BLANK[4:2]) begin
            blank_q <= wdata[NUM_HEX-1:0];
        end
    end
`else
    assign blank_q = BLANK_RST;
`endif

    always_comb begin
        rdata = 32'h0;
        if (io_hit) begin
            case (reg_idx)
                OFS_HEX[4:2]:   rdata = hex_q;
                OFS_LEDR[4:2]:  rdata = {{(32-LEDR_W){1'b0}}, ledr_q};
                OFS_LEDG[4:2]:  rdata = {{(32-LEDG_W){1'b0}}, ledg_q};
                OFS_SW[4:2]:    rdata = {{(32-SW_W){1'b0}}, sw_sync2_q};
                OFS_KEY[4:2]:   rdata = {{(32-NUM_KEYS){1'b0}}, key_state};
                OFS_EDGE[4:2]:  rdata = {{(32-NUM_KEYS){1'b0}}, edge_q};
`ifdef MIPS_IO_HEX_BLANK_EN
                OFS_BLANK[4:2]: rdata = {{(32-NUM_HEX){1'b0}}, blank_q};
`endif
                default:        rdata = 32'h0;
            endcase
        end
    end

    for (genvar h = 0; h < NUM_HEX; h++) begin : g_hex
        assign hex_seg[h] = blank_q[h] ? SEG_DARK : hex_decode(hex_q[4*h +: 4]);
    end

    assign {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} = hex_seg;
    assign ledr = ledr_q;
    assign ledg = ledg_q;

endmodule

// File: tb/tb_mips_io_ctrl.sv
// Scoreboard bench for mips_io_ctrl with a short debounce interval (4 cycles).
module tb_mips_io_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk, reset, we, io_hit;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  key_n;
    logic [17:0] sw, ledr;
    logic [8:0]  ledg;
    logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [7:0][6:0] hex_all;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    int          checks = 0;
    int          errors = 0;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    mips_io_ctrl #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .io_hit(io_hit), .key_n(key_n), .sw(sw),
        .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .ledr(ledr), .ledg(ledg)
    );

    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; #1;
        v = rdata;
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s: no observation, expected %h", e.name, e.exp);
            end else begin
                o = obs.pop_front();
                checks++;
                if (o !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                end
            end
        end
        obs.delete();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{$sformatf("reset_hex%0d", i), 32'h40});
            obs.push_back({25'b0, hex_all[i]});
        end
        sb.push_back('{"reset_ledr", 32'h0}); obs.push_back({14'b0, ledr});
        sb.push_back('{"reset_ledg", 32'h0}); obs.push_back({23'b0, ledg});
        sb.push_back('{"reset_key",  32'h0}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"reset_edge", 32'h0}); rd(BASE + 32'h14, v); obs.push_back(v);
        sb.push_back('{"reset_hit",  32'h1}); obs.push_back({31'b0, io_hit});
        drain();
    endtask

    task automatic test_hex();
        logic [31:0] v;
        logic [6:0]  exp_a [8] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000,
                                   7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
        logic [31:0] pat = 32'h456789EF;
        wr(BASE, 32'h0123ABCD);
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{$sformatf("hexA_%0d", i), {25'b0, exp_a[i]}});
            obs.push_back({25'b0, hex_all[i]});
        end
        sb.push_back('{"hexA_rb", 32'h0123ABCD}); rd(BASE, v); obs.push_back(v);
        wr(BASE, pat);
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{$sformatf("hexB_%0d", i), {25'b0, seg_ref[pat[4*i +: 4]]}});
            obs.push_back({25'b0, hex_all[i]});
        end
        drain();
    endtask

    task automatic test_leds();
        logic [31:0] v;
        wr(BASE + 32'h04, 32'hFFFFFFFF);
        wr(BASE + 32'h08, 32'hFFFFFFFF);
        wr(BASE + 32'h0C, 32'hFFFFFFFF);
        wr(BASE + 32'h1C, 32'hFFFFFFFF);
        sb.push_back('{"ledr_out", 32'h3FFFF}); obs.push_back({14'b0, ledr});
        sb.push_back('{"ledg_out", 32'h1FF});   obs.push_back({23'b0, ledg});
        sb.push_back('{"ledr_rb",  32'h3FFFF}); rd(BASE + 32'h04, v); obs.push_back(v);
        sb.push_back('{"ledg_rb",  32'h1FF});   rd(BASE + 32'h08, v); obs.push_back(v);
        sb.push_back('{"sw_ro",    32'h0});     rd(BASE + 32'h0C, v); obs.push_back(v);
        sb.push_back('{"rsvd_1c",  32'h0});     rd(BASE + 32'h1C, v); obs.push_back(v);
        drain();
    endtask

    task automatic test_sw();
        logic [31:0] v;
        sw = 18'h2A5A5;
        @(posedge clk); #1;
        sb.push_back('{"sw_1cyc", 32'h0}); rd(BASE + 32'h0C, v); obs.push_back(v);
        @(posedge clk); #1;
        sb.push_back('{"sw_2cyc", 32'h2A5A5}); rd(BASE + 32'h0C, v); obs.push_back(v);
        drain();
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        key_n[1] = 1'b0;
        repeat (2) @(posedge clk); #1;
        key_n[1] = 1'b1;
        repeat (10) @(posedge clk); #1;
        sb.push_back('{"glitch_key",  32'h0}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"glitch_edge", 32'h0}); rd(BASE + 32'h14, v); obs.push_back(v);
        drain();
    endtask

    task automatic test_key_press();
        logic [31:0] v;
        key_n[1] = 1'b0;
        repeat (10) @(posedge clk); #1;
        sb.push_back('{"press_key",  32'h2}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"press_edge", 32'h2}); rd(BASE + 32'h14, v); obs.push_back(v);
        wr(BASE + 32'h14, 32'hD);
        sb.push_back('{"w0_noeffect", 32'h2}); rd(BASE + 32'h14, v); obs.push_back(v);
        wr(BASE + 32'h14, 32'h2);
        sb.push_back('{"w1c_edge", 32'h0}); rd(BASE + 32'h14, v); obs.push_back(v);
        sb.push_back('{"w1c_key",  32'h2}); rd(BASE + 32'h10, v); obs.push_back(v);
        key_n[1] = 1'b1;
        repeat (10) @(posedge clk); #1;
        sb.push_back('{"release_key",  32'h0}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"release_edge", 32'h0}); rd(BASE + 32'h14, v); obs.push_back(v);
        drain();
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        // Synced after 2 edges, then 4 counting edges: the clear lands on the 6th edge.
        key_n[2] = 1'b0;
        repeat (5) @(posedge clk); #1;
        wr(BASE + 32'h14, 32'h4);
        sb.push_back('{"setwin_key",  32'h4}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"setwin_edge", 32'h4}); rd(BASE + 32'h14, v); obs.push_back(v);
        wr(BASE + 32'h14, 32'h4);
        sb.push_back('{"setwin_clr", 32'h0}); rd(BASE + 32'h14, v); obs.push_back(v);
        key_n[2] = 1'b1;
        repeat (10) @(posedge clk); #1;
        drain();
    endtask

    task automatic test_miss();
        logic [31:0] v;
        wr(BASE + 32'h40, 32'hDEADBEEF);
        wr(BASE + 32'h44, 32'h0);
        sb.push_back('{"miss_hit",  32'h0}); rd(BASE + 32'h40, v); obs.push_back({31'b0, io_hit});
        sb.push_back('{"miss_hex",  32'h456789EF}); rd(BASE, v); obs.push_back(v);
        sb.push_back('{"miss_ledr", 32'h3FFFF}); obs.push_back({14'b0, ledr});
        sb.push_back('{"lsb_ign",   32'h456789EF}); rd(BASE + 32'h3, v); obs.push_back(v);
        sb.push_back('{"top_hit",   32'h1}); rd(BASE + 32'h1F, v); obs.push_back({31'b0, io_hit});
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        key_n[0] = 1'b0;
        repeat (4) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back('{"rmid_key0", 32'h0});  rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"rmid_hex0", 32'h40}); obs.push_back({25'b0, hex0});
        sb.push_back('{"rmid_ledr", 32'h0});  obs.push_back({14'b0, ledr});
        repeat (3) @(posedge clk); #1;
        sb.push_back('{"rmid_key1", 32'h0}); rd(BASE + 32'h10, v); obs.push_back(v);
        repeat (10) @(posedge clk); #1;
        sb.push_back('{"rmid_key2",  32'h1}); rd(BASE + 32'h10, v); obs.push_back(v);
        sb.push_back('{"rmid_edge2", 32'h1}); rd(BASE + 32'h14, v); obs.push_back(v);
        key_n[0] = 1'b1;
        repeat (10) @(posedge clk); #1;
        drain();
    endtask

    task automatic test_blank();
        logic [31:0] v;
        wr(BASE + 32'h18, 32'h81);
`ifdef MIPS_IO_HEX_BLANK_EN
        sb.push_back('{"blank_rb",   32'h81}); rd(BASE + 32'h18, v); obs.push_back(v);
        sb.push_back('{"blank_hex0", 32'h7F}); obs.push_back({25'b0, hex0});
        sb.push_back('{"blank_hex7", 32'h7F}); obs.push_back({25'b0, hex7});
`else
        sb.push_back('{"rsvd_18",    32'h0});  rd(BASE + 32'h18, v); obs.push_back(v);
        sb.push_back('{"blank_hex0", 32'h40}); obs.push_back({25'b0, hex0});
        sb.push_back('{"blank_hex7", 32'h40}); obs.push_back({25'b0, hex7});
`endif
        sb.push_back('{"blank_hex1", 32'h40}); obs.push_back({25'b0, hex1});
        drain();
    endtask

    initial begin
        reset = 1'b1; addr = BASE; we = 1'b0; wdata = '0;
        key_n = 4'hF; sw = '0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        test_reset();
        test_hex();
        test_leds();
        test_sw();
        test_glitch();
        test_key_press();
        test_set_wins();
        test_miss();
        test_reset_mid();
        test_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
